// File: rtl/fpu_pkg.sv
// Shared definitions for the iterative FPU family: rounding-mode and
// operation encodings, the controller state type and the exponent bias helper.
package fpu_pkg;

    localparam logic [1:0] RM_RNE = 2'b00;
    localparam logic [1:0] RM_RTZ = 2'b01;
    localparam logic [1:0] RM_RTP = 2'b10;
    localparam logic [1:0] RM_RTN = 2'b11;

    localparam logic OP_MUL = 1'b0;
    localparam logic OP_DIV = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_UNPACK,
        ST_ITER,
        ST_NORM,
        ST_ROUND,
        ST_DONE
    } state_e;

    // Exponent bias for an exp_w-bit exponent field.
    function automatic int bias(input int exp_w);
        return (1 << (exp_w - 1)) - 1;
    endfunction

endpackage

// File: rtl/fpu_round.sv
// Combinational rounder: takes a normalised mantissa with guard/round/sticky,
// applies the rounding mode, renormalises on carry-out and packs the result,
// saturating to inf / max-finite on overflow and flushing to zero on underflow.
module fpu_round
    import fpu_pkg::*;
#(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                   sign,
    input  logic signed [EXP_W+1:0] exp_in,
    input  logic [MAN_W+3:0]       man_grs,    // {hidden, fraction, guard, round, sticky}
    input  logic [1:0]             round_mode,
    output logic [EXP_W+MAN_W:0]   y,
    output logic                   overflow
);

    localparam logic signed [EXP_W+1:0] EXP_MAX  = $signed({2'b00, {EXP_W{1'b1}}});
    localparam logic signed [EXP_W+1:0] EXP_ZERO = '0;
    localparam logic signed [EXP_W+1:0] EXP_ONE  = 1;

    logic [MAN_W:0]          man;
    logic                    guard;
    logic                    rest;
    logic                    inc;
    logic [MAN_W+1:0]        sum;
    logic signed [EXP_W+1:0] exp_r;
    logic [MAN_W-1:0]        frac;
    logic                    to_inf;

    // Round increment, carry renormalisation, then range handling.
    always_comb begin
        man   = man_grs[MAN_W+3:3];
        guard = man_grs[2];
        rest  = man_grs[1] | man_grs[0];
        case (round_mode)
            RM_RNE:  inc = guard & (rest | man[0]);
            RM_RTZ:  inc = 1'b0;
            RM_RTP:  inc = ~sign & (guard | rest);
            default: inc = sign & (guard | rest);
        endcase
        sum   = {1'b0, man} + {{(MAN_W+1){1'b0}}, inc};
        exp_r = exp_in;
        frac  = sum[MAN_W-1:0];
        if (sum[MAN_W+1]) begin
            exp_r = exp_in + EXP_ONE;
            frac  = sum[MAN_W:1];
        end
        to_inf = (round_mode == RM_RNE) ||
                 ((round_mode == RM_RTP) && !sign) ||
                 ((round_mode == RM_RTN) && sign);
        overflow = 1'b0;
        y        = '0;
        if (exp_r >= EXP_MAX) begin
            overflow = 1'b1;
            if (to_inf) y = {sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            else        y = {sign, {(EXP_W-1){1'b1}}, 1'b0, {MAN_W{1'b1}}};
        end else if (exp_r <= EXP_ZERO) begin
            y = {sign, {(EXP_W+MAN_W){1'b0}}};
        end else begin
            y = {sign, exp_r[EXP_W-1:0], frac};
        end
    end

endmodule

// File: rtl/fpu_iter.sv
// Iterative floating-point multiply/divide with valid/ready handshake.
// Multiply is shift-add, divide is restoring; one mantissa bit per cycle.
// Subnormal inputs are treated as signed zero.
// Build option: define FPU_STICKY_FLAGS_EN to add flag_clear and the
// sticky_error / sticky_overflow accumulators.
module fpu_iter
    import fpu_pkg::*;
#(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 op,
    input  logic [1:0]           round_mode,
    input  logic [EXP_W+MAN_W:0] A,
    input  logic [EXP_W+MAN_W:0] B,
    output logic                 out_valid,
    input  logic                 out_ready,
`ifdef FPU_STICKY_FLAGS_EN
    input  logic                 flag_clear,
    output logic                 sticky_error,
    output logic                 sticky_overflow,
`endif
    output logic [EXP_W+MAN_W:0] Y,
    output logic                 error,
    output logic                 overflow
);

    localparam int W     = 1 + EXP_W + MAN_W;
    localparam int M     = MAN_W + 1;
    localparam int N_MUL = MAN_W + 1;
    localparam int N_DIV = MAN_W + 3;
    localparam int CW    = $clog2(N_DIV + 1);
    localparam logic signed [EXP_W+1:0] BIAS_S = (EXP_W+2)'(bias(EXP_W));
    localparam logic signed [EXP_W+1:0] ONE_S  = 1;
    localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

    state_e state_q, state_d;

    logic                    op_q, op_d;
    logic [1:0]              rm_q, rm_d;
    logic [W-1:0]            a_q, a_d, b_q, b_d;
    logic [M-1:0]            ma_q, ma_d, mb_q, mb_d;
    logic                    sign_q, sign_d;
    logic signed [EXP_W+1:0] exp_q, exp_d;
    logic [2*M-1:0]          acc_q, acc_d;
    logic [M:0]              rem_q, rem_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [MAN_W+3:0]        mgrs_q, mgrs_d;
    logic [W-1:0]            y_q, y_d;
    logic                    err_q, err_d, ovf_q, ovf_d;

    logic [EXP_W-1:0] exp_a, exp_b;
    logic [MAN_W-1:0] frac_a, frac_b;
    logic             nan_a, nan_b, inf_a, inf_b, zero_a, zero_b;
    logic             res_sign, invalid, is_inf, is_zero, special;
    logic [W-1:0]     special_y;

    logic [M:0]       mul_sum;
    logic             div_ge;
    logic [M:0]       rem_sel;
    logic [2*M-1:0]   norm_p;
    logic [N_DIV-1:0] quo, norm_quo;

    logic [W-1:0]     rnd_y;
    logic             rnd_ovf;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (in_valid) state_d = ST_UNPACK;
            ST_UNPACK: state_d = special ? ST_DONE : ST_ITER;
            ST_ITER:   if (cnt_q == CW'(1)) state_d = ST_NORM;
            ST_NORM:   state_d = ST_ROUND;
            ST_ROUND:  state_d = ST_DONE;
            ST_DONE:   if (out_ready) state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Handshake outputs; in_ready is held low while reset is asserted.
    always_comb begin
        in_ready  = (state_q == ST_IDLE) && !reset;
        out_valid = (state_q == ST_DONE);
    end

    // Operand decode and special-case classification.
    always_comb begin
        exp_a    = a_q[W-2:MAN_W];
        exp_b    = b_q[W-2:MAN_W];
        frac_a   = a_q[MAN_W-1:0];
        frac_b   = b_q[MAN_W-1:0];
        nan_a    = (exp_a == '1) && (frac_a != '0);
        nan_b    = (exp_b == '1) && (frac_b != '0);
        inf_a    = (exp_a == '1) && (frac_a == '0);
        inf_b    = (exp_b == '1) && (frac_b == '0);
        zero_a   = (exp_a == '0);
        zero_b   = (exp_b == '0);
        res_sign = a_q[W-1] ^ b_q[W-1];
        if (op_q == OP_MUL) begin
            invalid = nan_a | nan_b | (zero_a & inf_b) | (inf_a & zero_b);
            is_inf  = inf_a | inf_b;
            is_zero = zero_a | zero_b;
        end else begin
            invalid = nan_a | nan_b | (zero_b & ~inf_a) | (inf_a & inf_b);
            is_inf  = inf_a;
            is_zero = zero_a | inf_b;
        end
        special = invalid | is_inf | is_zero;
        if (invalid)     special_y = QNAN;
        else if (is_inf) special_y = {res_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        else             special_y = {res_sign, {(W-1){1'b0}}};
    end

    // Datapath next-state: capture, unpack, iterate, normalise, round.
    always_comb begin
        op_d   = op_q;
        rm_d   = rm_q;
        a_d    = a_q;
        b_d    = b_q;
        ma_d   = ma_q;
        mb_d   = mb_q;
        sign_d = sign_q;
        exp_d  = exp_q;
        acc_d  = acc_q;
        rem_d  = rem_q;
        cnt_d  = cnt_q;
        mgrs_d = mgrs_q;
        y_d    = y_q;
        err_d  = err_q;
        ovf_d  = ovf_q;

        mul_sum  = {1'b0, acc_q[2*M-1:M]} + (acc_q[0] ? {1'b0, ma_q} : '0);
        div_ge   = rem_q >= {1'b0, mb_q};
        rem_sel  = div_ge ? (rem_q - {1'b0, mb_q}) : rem_q;
        norm_p   = acc_q[2*M-1] ? acc_q : {acc_q[2*M-2:0], 1'b0};
        quo      = acc_q[N_DIV-1:0];
        norm_quo = quo[N_DIV-1] ? quo : {quo[N_DIV-2:0], 1'b0};

        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    op_d = op;
                    rm_d = round_mode;
                    a_d  = A;
                    b_d  = B;
                end
            end
            ST_UNPACK: begin
                sign_d = res_sign;
                ma_d   = {1'b1, frac_a};
                mb_d   = {1'b1, frac_b};
                if (op_q == OP_MUL) begin
                    exp_d = $signed({2'b00, exp_a}) + $signed({2'b00, exp_b}) - BIAS_S;
                    acc_d = {{M{1'b0}}, 1'b1, frac_b};
                    cnt_d = CW'(N_MUL);
                end else begin
                    exp_d = $signed({2'b00, exp_a}) - $signed({2'b00, exp_b}) + BIAS_S;
                    acc_d = '0;
                    cnt_d = CW'(N_DIV);
                end
                rem_d = {2'b01, frac_a};
                if (special) begin
                    y_d   = special_y;
                    err_d = invalid;
                    ovf_d = 1'b0;
                end
            end
            ST_ITER: begin
                cnt_d = cnt_q - 1'b1;
                if (op_q == OP_MUL) begin
                    acc_d = {mul_sum, acc_q[M-1:1]};
                end else begin
                    acc_d = {acc_q[2*M-2:0], div_ge};
                    rem_d = {rem_sel[M-1:0], 1'b0};
                end
            end
            ST_NORM: begin
                if (op_q == OP_MUL) begin
                    mgrs_d = {norm_p[2*M-1:M], norm_p[M-1], norm_p[M-2], |norm_p[M-3:0]};
                    if (acc_q[2*M-1]) exp_d = exp_q + ONE_S;
                end else begin
                    // Only guard is known exactly; round folds into sticky via the remainder.
                    mgrs_d = {norm_quo[N_DIV-1:2], norm_quo[1], norm_quo[0], |rem_q};
                    if (!quo[N_DIV-1]) exp_d = exp_q - ONE_S;
                end
            end
            ST_ROUND: begin
                y_d   = rnd_y;
                ovf_d = rnd_ovf;
                err_d = 1'b0;
            end
            ST_DONE: begin
                if (out_ready) begin
                    y_d   = '0;
                    err_d = 1'b0;
                    ovf_d = 1'b0;
                end
            end
            default: ;
        endcase
    end

    // Datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            op_q   <= OP_MUL;
            rm_q   <= RM_RNE;
            a_q    <= '0;
            b_q    <= '0;
            ma_q   <= '0;
            mb_q   <= '0;
            sign_q <= 1'b0;
            exp_q  <= '0;
            acc_q  <= '0;
            rem_q  <= '0;
            cnt_q  <= '0;
            mgrs_q <= '0;
            y_q    <= '0;
            err_q  <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            op_q   <= op_d;
            rm_q   <= rm_d;
            a_q    <= a_d;
            b_q    <= b_d;
            ma_q   <= ma_d;
            mb_q   <= mb_d;
            sign_q <= sign_d;
            exp_q  <= exp_d;
            acc_q  <= acc_d;
            rem_q  <= rem_d;
            cnt_q  <= cnt_d;
            mgrs_q <= mgrs_d;
            y_q    <= y_d;
            err_q  <= err_d;
            ovf_q  <= ovf_d;
        end
    end

    fpu_round #(
        .EXP_W(EXP_W),
        .MAN_W(MAN_W)
    ) u_round (
        .sign      (sign_q),
        .exp_in    (exp_q),
        .man_grs   (mgrs_q),
        .round_mode(rm_q),
        .y         (rnd_y),
        .overflow  (rnd_ovf)
    );

    assign Y        = y_q;
    assign error    = err_q;
    assign overflow = ovf_q;

`ifdef FPU_STICKY_FLAGS_EN
    logic sticky_err_q, sticky_err_d, sticky_ovf_q, sticky_ovf_d;

    // Sticky accumulation; a set on the handshake overrides a coincident clear.
    always_comb begin
        sticky_err_d = flag_clear ? 1'b0 : sticky_err_q;
        sticky_ovf_d = flag_clear ? 1'b0 : sticky_ovf_q;
        if ((state_q == ST_DONE) && out_ready) begin
            sticky_err_d = sticky_err_d | err_q;
            sticky_ovf_d = sticky_ovf_d | ovf_q;
        end
    end

    // Sticky flag registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            sticky_err_q <= 1'b0;
            sticky_ovf_q <= 1'b0;
        end else begin
            sticky_err_q <= sticky_err_d;
            sticky_ovf_q <= sticky_ovf_d;
        end
    end

    assign sticky_error    = sticky_err_q;
    assign sticky_overflow = sticky_ovf_q;
`endif

endmodule

// File: tb/tb_fpu_iter.sv
// Bench for fpu_iter: directed vector table, handshake/reset sequences,
// a half-precision instance, and random operations against an exact-arithmetic model.
module tb_fpu_iter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0, in_ready, op = 1'b0, out_valid, out_ready = 1'b0;
    logic [1:0]  round_mode = 2'b00;
    logic [31:0] A = '0, B = '0, Y;
    logic        error, overflow;

    logic        h_in_valid = 1'b0, h_in_ready, h_op = 1'b0, h_out_valid, h_out_ready = 1'b0;
    logic [1:0]  h_rm = 2'b00;
    logic [15:0] h_a = '0, h_b = '0, h_y;
    logic        h_error, h_overflow;

`ifdef FPU_STICKY_FLAGS_EN
    logic        s_err, s_ovf, h_s_err, h_s_ovf;
`endif

    int n_pass = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    fpu_iter u_dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .round_mode(round_mode), .A(A), .B(B),
        .out_valid(out_valid), .out_ready(out_ready),
`ifdef FPU_STICKY_FLAGS_EN
        .flag_clear(1'b0), .sticky_error(s_err), .sticky_overflow(s_ovf),
`endif
        .Y(Y), .error(error), .overflow(overflow)
    );

    fpu_iter #(.EXP_W(5), .MAN_W(10)) u_half (
        .clk(clk), .reset(reset), .in_valid(h_in_valid), .in_ready(h_in_ready),
        .op(h_op), .round_mode(h_rm), .A(h_a), .B(h_b),
        .out_valid(h_out_valid), .out_ready(h_out_ready),
`ifdef FPU_STICKY_FLAGS_EN
        .flag_clear(1'b0), .sticky_error(h_s_err), .sticky_overflow(h_s_ovf),
`endif
        .Y(h_y), .error(h_error), .overflow(h_overflow)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Exact reference: significand product / long quotient, then IEEE-style rounding.
    function automatic void model(input logic [31:0] a, input logic [31:0] b, input logic o,
                                  input logic [1:0] rm, output logic [31:0] y,
                                  output logic err, output logic ovf, output int lat);
        int ea, eb, e, p, sh;
        logic na, nb, ia, ib, za, zb, s, g, rest, up;
        logic [63:0] num, den, x, man;
        ea = int'(a[30:23]);
        eb = int'(b[30:23]);
        na = (ea == 255) && (a[22:0] != 0);
        nb = (eb == 255) && (b[22:0] != 0);
        ia = (ea == 255) && (a[22:0] == 0);
        ib = (eb == 255) && (b[22:0] == 0);
        za = (ea == 0);
        zb = (eb == 0);
        s = a[31] ^ b[31];
        err = 1'b0; ovf = 1'b0; lat = 2; y = '0;
        if (na || nb || (!o && ((za && ib) || (ia && zb))) || (o && ((zb && !ia) || (ia && ib)))) begin
            err = 1'b1; y = 32'h7FC00000; return;
        end
        if (!o ? (ia || ib) : ia) begin y = {s, 8'hFF, 23'h0}; return; end
        if (!o ? (za || zb) : (za || ib)) begin y = {s, 31'h0}; return; end
        lat = o ? 30 : 28;
        if (!o) begin
            x = 64'({1'b1, a[22:0]}) * 64'({1'b1, b[22:0]});
            rest = 1'b0;
            e = ea + eb - 127 - 46;
        end else begin
            num = {1'b1, a[22:0], 40'h0};
            den = 64'({1'b1, b[22:0]});
            x = num / den;
            rest = (num % den) != 0;
            e = ea - eb + 127 - 40;
        end
        p = 63;
        while (p > 0 && !x[p]) p--;
        e += p;
        sh = p - 23;
        man = x >> sh;
        g = x[sh-1];
        rest = rest || ((x & ((64'd1 << (sh - 1)) - 64'd1)) != 0);
        case (rm)
            2'b00:   up = g && (rest || man[0]);
            2'b01:   up = 1'b0;
            2'b10:   up = !s && (g || rest);
            default: up = s && (g || rest);
        endcase
        man = man + 64'(up);
        if (man[24]) begin man = man >> 1; e++; end
        if (e >= 255) begin
            ovf = 1'b1;
            if (rm == 2'b00 || (rm == 2'b10 && !s) || (rm == 2'b11 && s)) y = {s, 8'hFF, 23'h0};
            else y = {s, 8'hFE, 23'h7FFFFF};
        end else if (e <= 0) begin
            y = {s, 31'h0};
        end else begin
            y = {s, e[7:0], man[22:0]};
        end
    endfunction

    function automatic logic [31:0] rnd_operand();
        int k = $urandom_range(0, 9);
        logic [31:0] v = $urandom;
        if (k < 7)       v[30:23] = 8'($urandom_range(90, 165));
        else if (k == 7) v[30:0] = '0;
        else if (k == 8) v[30:0] = {8'hFF, 23'h0};
        return v;
    endfunction

    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic o, input logic [1:0] rm);
        int w = 0;
        @(negedge clk);
        while (!in_ready && w < 100) begin @(negedge clk); w++; end
        if (!in_ready) chk("in_ready_wait", 64'(in_ready), 64'd1);
        A = a; B = b; op = o; round_mode = rm; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(output int lat);
        lat = 1;
        while (!out_valid && lat < 100) begin @(posedge clk); #1; lat++; end
        if (!out_valid) chk("out_valid_wait", 64'(out_valid), 64'd1);
    endtask

    task automatic take_result();
        @(negedge clk); out_ready = 1'b1;
        @(posedge clk); #1; out_ready = 1'b0;
    endtask

    typedef struct {
        logic [31:0] a, b;
        logic        o;
        logic [1:0]  rm;
        logic [31:0] y;
        logic        err, ovf;
        int          lat;
    } vec_t;

    vec_t vecs[15];

    initial begin
        int lat, seen;
        logic [31:0] ry, ra, rb;
        logic rerr, rovf, ro;
        logic [1:0] rrm;
        int rlat;

        vecs[0]  = '{32'h40000000, 32'h40400000, 1'b0, 2'b00, 32'h40C00000, 1'b0, 1'b0, 28};
        vecs[1]  = '{32'h3F800000, 32'h40400000, 1'b1, 2'b00, 32'h3EAAAAAB, 1'b0, 1'b0, 30};
        vecs[2]  = '{32'h3F800000, 32'h40400000, 1'b1, 2'b01, 32'h3EAAAAAA, 1'b0, 1'b0, 30};
        vecs[3]  = '{32'h3F800000, 32'h40400000, 1'b1, 2'b11, 32'h3EAAAAAA, 1'b0, 1'b0, 30};
        vecs[4]  = '{32'h3F800000, 32'h40400000, 1'b1, 2'b10, 32'h3EAAAAAB, 1'b0, 1'b0, 30};
        vecs[5]  = '{32'h7F000000, 32'h7F000000, 1'b0, 2'b00, 32'h7F800000, 1'b0, 1'b1, 28};
        vecs[6]  = '{32'h7F000000, 32'h7F000000, 1'b0, 2'b01, 32'h7F7FFFFF, 1'b0, 1'b1, 28};
        vecs[7]  = '{32'hFF000000, 32'h7F000000, 1'b0, 2'b11, 32'hFF800000, 1'b0, 1'b1, 28};
        vecs[8]  = '{32'h3F800000, 32'h00000000, 1'b1, 2'b00, 32'h7FC00000, 1'b1, 1'b0, 2};
        vecs[9]  = '{32'h00000000, 32'h7F800000, 1'b0, 2'b00, 32'h7FC00000, 1'b1, 1'b0, 2};
        vecs[10] = '{32'hC0000000, 32'h40400000, 1'b0, 2'b01, 32'hC0C00000, 1'b0, 1'b0, 28};
        vecs[11] = '{32'h3F800000, 32'h7F800000, 1'b1, 2'b00, 32'h00000000, 1'b0, 1'b0, 2};
        vecs[12] = '{32'h7F800000, 32'h40000000, 1'b0, 2'b00, 32'h7F800000, 1'b0, 1'b0, 2};
        vecs[13] = '{32'hBF800000, 32'h40400000, 1'b1, 2'b11, 32'hBEAAAAAB, 1'b0, 1'b0, 30};
        vecs[14] = '{32'h00800000, 32'h00800000, 1'b0, 2'b00, 32'h00000000, 1'b0, 1'b0, 28};

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_y", 64'(Y), 64'd0);
        chk("rst_error", 64'(error), 64'd0);
        chk("rst_overflow", 64'(overflow), 64'd0);
        @(negedge clk); reset = 1'b0;
        #1;
        chk("post_rst_in_ready", 64'(in_ready), 64'd1);

        // Directed vectors.
        foreach (vecs[i]) begin
            issue(vecs[i].a, vecs[i].b, vecs[i].o, vecs[i].rm);
            wait_valid(lat);
            chk($sformatf("vec%0d_y", i), 64'(Y), 64'(vecs[i].y));
            chk($sformatf("vec%0d_err", i), 64'(error), 64'(vecs[i].err));
            chk($sformatf("vec%0d_ovf", i), 64'(overflow), 64'(vecs[i].ovf));
            chk($sformatf("vec%0d_lat", i), 64'(lat), 64'(vecs[i].lat));
            take_result();
        end

        // Back-pressure: result held, new requests ignored.
        issue(32'h40000000, 32'h40400000, 1'b0, 2'b00);
        wait_valid(lat);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            in_valid = 1'b1; A = 32'h3F800000; B = 32'h3F800000; op = 1'b1;
            @(posedge clk); #1;
            chk("hold_y", 64'(Y), 64'h40C00000);
            chk("hold_in_ready", 64'(in_ready), 64'd0);
            chk("hold_out_valid", 64'(out_valid), 64'd1);
        end
        @(negedge clk); in_valid = 1'b0;
        take_result();
        chk("after_hs_out_valid", 64'(out_valid), 64'd0);
        chk("after_hs_in_ready", 64'(in_ready), 64'd1);
        repeat (3) @(posedge clk);
        #1;
        chk("no_ghost_op", 64'(out_valid), 64'd0);

        // Reset during ITER aborts with no output.
        issue(32'h3F800000, 32'h40400000, 1'b1, 2'b00);
        repeat (5) @(posedge clk);
        @(negedge clk); reset = 1'b1;
        @(posedge clk); #1;
        chk("midrst_out_valid", 64'(out_valid), 64'd0);
        chk("midrst_y", 64'(Y), 64'd0);
        chk("midrst_in_ready", 64'(in_ready), 64'd0);
        @(negedge clk); reset = 1'b0;
        #1;
        chk("midrst_release_in_ready", 64'(in_ready), 64'd1);
        seen = 0;
        repeat (40) begin @(posedge clk); #1; if (out_valid) seen++; end
        chk("midrst_no_output", 64'(seen), 64'd0);

        // Half-precision instance.
        @(negedge clk);
        h_a = 16'h4000; h_b = 16'h4200; h_op = 1'b0; h_rm = 2'b00; h_in_valid = 1'b1;
        @(posedge clk); #1;
        h_in_valid = 1'b0;
        lat = 1;
        while (!h_out_valid && lat < 100) begin @(posedge clk); #1; lat++; end
        chk("half_y", 64'(h_y), 64'h4600);
        chk("half_err", 64'(h_error), 64'd0);
        chk("half_ovf", 64'(h_overflow), 64'd0);
        chk("half_lat", 64'(lat), 64'd15);
        @(negedge clk); h_out_ready = 1'b1;
        @(posedge clk); #1; h_out_ready = 1'b0;

        // Random operations against the reference model.
        for (int r = 0; r < 40; r++) begin
            ra = rnd_operand();
            rb = rnd_operand();
            ro = 1'($urandom_range(0, 1));
            rrm = 2'($urandom_range(0, 3));
            model(ra, rb, ro, rrm, ry, rerr, rovf, rlat);
            issue(ra, rb, ro, rrm);
            wait_valid(lat);
            chk($sformatf("rnd%0d_y a=%h b=%h op=%0d rm=%0d", r, ra, rb, ro, rrm), 64'(Y), 64'(ry));
            chk($sformatf("rnd%0d_err", r), 64'(error), 64'(rerr));
            chk($sformatf("rnd%0d_ovf", r), 64'(overflow), 64'(rovf));
            chk($sformatf("rnd%0d_lat", r), 64'(lat), 64'(rlat));
            take_result();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d", n_pass, n_total);
        $fatal(1, "watchdog");
    end

endmodule
